// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 input stage.
// Holds the block-size constants, the loader state encoding and a helper
// that sizes the byte counter for a given block width.
package aes_pkg;

   localparam int AES_BLOCK_W     = 128;
   localparam int AES_BLOCK_BYTES = AES_BLOCK_W / 8;

   typedef enum logic [1:0] {
      LOAD_KEY = 2'd0,
      LOAD_PT  = 2'd1,
      PRESENT  = 2'd2
   } loader_state_t;

   // A one-byte block would give a zero-width counter; keep at least one bit.
   function automatic int cnt_width(input int block_w);
      int bytes;
      bytes = block_w / 8;
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

   localparam int AES_CNT_W = cnt_width(AES_BLOCK_W);

endpackage

// File: rtl/aes_byte_shifter.sv
// Byte-wide shift register used to assemble a key or a plaintext block.
// Each enabled cycle shifts the register left by one byte and inserts
// byte_in at the least-significant byte, so the first byte of a block ends
// up in the most-significant byte once BLOCK_W/8 bytes have been shifted in.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, clears the register
//   shift_en - shift one byte in this cycle
//   byte_in  - byte to insert at the low end
//   data_out - current register contents
module aes_byte_shifter
   import aes_pkg::*;
#(
   parameter int BLOCK_W = AES_BLOCK_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               shift_en,
   input  logic [7:0]         byte_in,
   output logic [BLOCK_W-1:0] data_out
);

   localparam int NBYTES = BLOCK_W / 8;

   logic [BLOCK_W-1:0] data_reg;
   logic [BLOCK_W-1:0] data_next;

   // Every byte lane takes the lane below it; lane 0 takes the new byte.
   genvar gi;
   generate
      for (gi = 0; gi < NBYTES; gi++) begin : g_lane
         if (gi == 0) begin : g_first
            assign data_next[7:0] = byte_in;
         end else begin : g_rest
            assign data_next[gi*8 +: 8] = data_reg[(gi-1)*8 +: 8];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         data_reg <= '0;
      end else if (shift_en) begin
         data_reg <= data_next;
      end
   end

   assign data_out = data_reg;

endmodule

// File: rtl/aes_block_loader.sv
// Input stage for the AES-128 core: collects a key and a plaintext from a
// byte stream (valid/ready) and presents the pair over out_valid/out_ready.
// The key may be kept for the next block so only plaintext is re-sent.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_data/in_valid/in_ready - byte stream handshake
//   flush                 - abort the current assembly, restart at key byte 0
//   keep_key              - sampled at the output handshake; reuse the key
//   key_out/plaintext_out - assembled pair
//   out_valid/out_ready   - output handshake
//   loading_key           - high while the key is being collected
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int BLOCK_W     = AES_BLOCK_W,
   parameter bit KEEP_KEY_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               flush,
   input  logic               keep_key,
   output logic [BLOCK_W-1:0] key_out,
   output logic [BLOCK_W-1:0] plaintext_out,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               loading_key
);

   localparam int NBYTES = BLOCK_W / 8;
   localparam int CNT_W  = cnt_width(BLOCK_W);

   loader_state_t    state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             out_valid_reg, out_valid_next;
   logic             key_shift, pt_shift;
   logic             accept;
   logic             last_byte;

   // flush and rst both block acceptance so a byte offered in that cycle is
   // unambiguously dropped rather than half-counted.
   assign in_ready  = ((state_reg == LOAD_KEY) || (state_reg == LOAD_PT)) && !rst && !flush;
   assign accept    = in_valid && in_ready;
   assign last_byte = (cnt_reg == CNT_W'(NBYTES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= LOAD_KEY;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         out_valid_reg <= out_valid_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      out_valid_next = out_valid_reg;
      key_shift      = 1'b0;
      pt_shift       = 1'b0;
      if (flush) begin
         state_next     = LOAD_KEY;
         cnt_next       = '0;
         out_valid_next = 1'b0;
      end else begin
         case (state_reg)
            LOAD_KEY: begin
               if (accept) begin
                  key_shift = 1'b1;
                  if (last_byte) begin
                     cnt_next   = '0;
                     state_next = LOAD_PT;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
            LOAD_PT: begin
               if (accept) begin
                  pt_shift = 1'b1;
                  if (last_byte) begin
                     cnt_next       = '0;
                     state_next     = PRESENT;
                     out_valid_next = 1'b1;
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
            end
            PRESENT: begin
               if (out_valid_reg && out_ready) begin
                  out_valid_next = 1'b0;
                  state_next     = (KEEP_KEY_EN && keep_key) ? LOAD_PT : LOAD_KEY;
               end
            end
            default: begin
               state_next = LOAD_KEY;
               cnt_next   = '0;
            end
         endcase
      end
   end

   aes_byte_shifter #(.BLOCK_W(BLOCK_W)) u_key_shifter (
      .clk      (clk),
      .rst      (rst),
      .shift_en (key_shift),
      .byte_in  (in_data),
      .data_out (key_out)
   );

   aes_byte_shifter #(.BLOCK_W(BLOCK_W)) u_pt_shifter (
      .clk      (clk),
      .rst      (rst),
      .shift_en (pt_shift),
      .byte_in  (in_data),
      .data_out (plaintext_out)
   );

   assign out_valid   = out_valid_reg;
   assign loading_key = (state_reg == LOAD_KEY);

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed plus randomized bench for aes_block_loader. A reference model
// keeps the last 16 bytes written to each field in queues and tracks which
// field is being filled; every cycle the DUT is compared against it.
module tb_aes_block_loader;

   localparam int BW = 128;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic          keep_key;
   logic [BW-1:0] key_out;
   logic [BW-1:0] plaintext_out;
   logic          out_valid;
   logic          out_ready;
   logic          loading_key;

   aes_block_loader #(.BLOCK_W(BW), .KEEP_KEY_EN(1'b1)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .flush         (flush),
      .keep_key      (keep_key),
      .key_out       (key_out),
      .plaintext_out (plaintext_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .loading_key   (loading_key)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   // Reference model: phase 0 = collecting key, 1 = collecting plaintext,
   // 2 = pair on offer.
   int         m_phase;
   int         m_count;
   logic       m_valid;
   int         m_blocks;
   logic [7:0] m_key_q[$];
   logic [7:0] m_pt_q[$];

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Oldest byte of the queue is the most-significant byte of the field.
   function automatic logic [BW-1:0] pack(input logic [7:0] q[$]);
      logic [BW-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[BW-1-8*i -: 8] = q[i];
      return r;
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_count = 0;
      m_valid = 1'b0;
      m_key_q = {};
      m_pt_q  = {};
      for (int i = 0; i < 16; i++) begin
         m_key_q.push_back(8'h00);
         m_pt_q.push_back(8'h00);
      end
   endtask

   task automatic model_edge(input logic [7:0] d, input logic v, input logic r,
                             input logic fl, input logic ordy, input logic kk);
      if (r) begin
         model_reset();
      end else if (fl) begin
         m_phase = 0;
         m_count = 0;
         m_valid = 1'b0;
      end else if (m_phase == 0) begin
         if (v) begin
            m_key_q.push_back(d);
            void'(m_key_q.pop_front());
            m_count++;
            if (m_count == 16) begin
               m_count = 0;
               m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (v) begin
            m_pt_q.push_back(d);
            void'(m_pt_q.pop_front());
            m_count++;
            if (m_count == 16) begin
               m_count = 0;
               m_phase = 2;
               m_valid = 1'b1;
            end
         end
      end else if (ordy) begin
         $display("block %0d key=%h pt=%h keep_key=%0b", m_blocks, pack(m_key_q), pack(m_pt_q), kk);
         m_blocks++;
         m_valid = 1'b0;
         m_phase = kk ? 1 : 0;
      end
   endtask

   // One clock cycle: drive, check in_ready, clock, update model, check state.
   task automatic step(input logic [7:0] d, input logic v, input logic r,
                       input logic fl, input logic ordy, input logic kk);
      in_data   = d;
      in_valid  = v;
      rst       = r;
      flush     = fl;
      out_ready = ordy;
      keep_key  = kk;
      #1;
      check("in_ready", BW'(in_ready), BW'((m_phase != 2) && !r && !fl));
      @(posedge clk);
      model_edge(d, v, r, fl, ordy, kk);
      #1;
      check("out_valid", BW'(out_valid), BW'(m_valid));
      check("loading_key", BW'(loading_key), BW'(m_phase == 0));
      check("key_out", key_out, pack(m_key_q));
      check("plaintext_out", plaintext_out, pack(m_pt_q));
   endtask

   task automatic send(input logic [7:0] d);
      step(d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic send_random(input int n);
      for (int i = 0; i < n; i++) send(8'($urandom));
   endtask

   task automatic handshake(input logic kk);
      step(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, kk);
   endtask

   initial begin
      m_blocks = 0;
      model_reset();
      step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Basic load: key 00..0F, plaintext 10..1F back to back.
      for (int i = 0; i < 32; i++) send(8'(i));
      check("basic_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("basic_pt", plaintext_out, 128'h101112131415161718191A1B1C1D1E1F);
      check("basic_valid", BW'(out_valid), BW'(1));

      // Backpressure: bytes offered while the pair waits are not taken.
      for (int i = 0; i < 10; i++) send(8'hAA);
      check("bp_key_stable", key_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("bp_pt_stable", plaintext_out, 128'h101112131415161718191A1B1C1D1E1F);
      step(8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      send(8'h55);
      check("bp_first_key_byte", BW'(key_out[7:0]), BW'(8'h55));

      // Key reuse: reload a clean key, then a second block with only plaintext.
      step(8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) send(8'(i));
      send_random(16);
      handshake(1'b1);
      for (int i = 0; i < 16; i++) send(8'hFF);
      check("reuse_key", key_out, 128'h000102030405060708090A0B0C0D0E0F);
      check("reuse_pt", plaintext_out, {16{8'hFF}});
      check("reuse_valid", BW'(out_valid), BW'(1));
      handshake(1'b0);

      // Gappy input: valid on alternate cycles.
      for (int i = 0; i < 16; i++) begin
         step(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         step(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         step(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         step(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check("gappy_key", key_out, {16{8'h11}});
      check("gappy_pt", plaintext_out, {16{8'h22}});
      handshake(1'b0);

      // Flush mid-plaintext, then a fresh full sequence.
      send_random(21);
      step(8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("flush_loading_key", BW'(loading_key), BW'(1));
      for (int i = 0; i < 16; i++) send(8'hC0 + 8'(i));
      for (int i = 0; i < 16; i++) send(8'hD0 + 8'(i));
      check("flush_key", key_out, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
      check("flush_pt", plaintext_out, 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF);
      handshake(1'b0);

      // Randomized traffic: gaps, stalls and random key reuse.
      begin
         int target;
         target = m_blocks + 4;
         for (int c = 0; c < 2000 && m_blocks < target; c++) begin
            step(8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
                 1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
         end
         check("random_blocks_done", BW'(m_blocks >= target), BW'(1));
      end

      // Reset while a pair is on offer.
      step(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_random(32);
      check("pre_reset_valid", BW'(out_valid), BW'(1));
      step(8'h99, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check("reset_valid", BW'(out_valid), BW'(0));
      check("reset_key", key_out, '0);
      check("reset_pt", plaintext_out, '0);
      check("reset_loading_key", BW'(loading_key), BW'(1));
      send(8'h3C);
      check("post_reset_byte", key_out, 128'h3C);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
Upstream input stage for the AES-128 core `main`. It takes a byte stream (for example from a UART receiver) over a valid/ready handshake and assembles a 128-bit key and a 128-bit plaintext. It then presents the pair to the core with an out_valid/out_ready handshake. A key can optionally be reused across blocks so that only plaintext bytes need to be re-sent.

Parameters:
- BLOCK_W, 128, width of the key and of the plaintext in bits; must be a multiple of 8.
- KEEP_KEY_EN, 1, when 1 the keep_key input is honoured; when 0 it is ignored and a key is always loaded.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  the loader accepts a byte this cycle.
- flush  input  1  synchronous abort of the current assembly.
- keep_key  input  1  sampled at the output handshake; when 1, the next block reuses the current key.
- key_out  output  BLOCK_W  assembled key, to core `key`.
- plaintext_out  output  BLOCK_W  assembled plaintext, to core `plaintext`.
- out_valid  output  1  key_out and plaintext_out hold a complete pair.
- out_ready  input  1  downstream consumes the pair.
- loading_key  output  1  the state is LOAD_KEY (status/LED).

Behaviour:
- States: LOAD_KEY, LOAD_PT, PRESENT. Byte counter cnt is log2(BLOCK_W/8) bits wide.
- Reset (rst=1 at an edge):
  - state=LOAD_KEY, cnt=0, key_out=0, plaintext_out=0, out_valid=0.
  - in_ready is 0 while rst=1.
- in_ready = (state is LOAD_KEY or LOAD_PT) and not rst and not flush. It is combinational from state.
- Byte acceptance occurs on an edge where in_valid and in_ready are both 1.
- LOAD_KEY:
  - On each accepted byte: key_out <= {key_out[BLOCK_W-9:0], in_data}, cnt <= cnt+1. The first byte ends in key_out[BLOCK_W-1:BLOCK_W-8].
  - When the byte with cnt = BLOCK_W/8-1 is accepted: cnt <= 0, state <= LOAD_PT.
- LOAD_PT:
  - Same shift scheme into plaintext_out.
  - When the last byte is accepted: cnt <= 0, state <= PRESENT, out_valid <= 1.
- Latency: out_valid is high in the cycle immediately after the edge that accepted the final plaintext byte.
- PRESENT:
  - key_out, plaintext_out and out_valid are held stable; in_ready=0.
  - On out_valid and out_ready at an edge: out_valid <= 0.
  - Next state: if KEEP_KEY_EN=1 and keep_key=1, state <= LOAD_PT; otherwise state <= LOAD_KEY.
  - No bypass: a byte presented in the same cycle as the output handshake is not accepted, because in_ready is 0.
- key_out during plaintext loading:
  - key_out never changes in LOAD_PT or PRESENT.
  - When a key is reused, key_out keeps its value across blocks.
  - plaintext_out is overwritten progressively during LOAD_PT and is meaningful only while out_valid=1.
- flush=1 at an edge (any state):
  - state <= LOAD_KEY, cnt <= 0, out_valid <= 0.
  - key_out and plaintext_out keep their contents.
  - in_ready is forced to 0 that cycle, so no byte is lost ambiguously.
- Priority: rst > flush > handshakes.
- Reset or flush mid-block: the partial field is discarded logically, and the next accepted byte counts as key byte 0.
- in_valid may be deasserted between bytes for any number of cycles; cnt holds.
- loading_key = (state == LOAD_KEY).

Decomposition:
- Shared package aes_pkg:
  - constants AES_BLOCK_W=128 and AES_BLOCK_BYTES=16;
  - the state encoding (LOAD_KEY=2'd0, LOAD_PT=2'd1, PRESENT=2'd2);
  - the byte-counter width.
- One natural sub-module, aes_byte_shifter: a parameterised BLOCK_W shift register with load-enable. It is instantiated twice, once for the key and once for the plaintext.
- The control FSM and counter stay in aes_block_loader.

Test Plan:
- Basic load:
  - Stimulus: after reset, send bytes 0x00..0x0F, then 0x10..0x1F, with in_valid held high continuously.
  - Required response: out_valid rises one cycle after the 32nd accept; key_out = 0x000102030405060708090A0B0C0D0E0F; plaintext_out = 0x101112131415161718191A1B1C1D1E1F; in_ready=0 while PRESENT.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles while in_valid=1 with byte 0xAA.
  - Required response: outputs are stable and no byte is accepted. When out_ready=1 with keep_key=0, state becomes LOAD_KEY and the next byte 0x55 lands in key_out[7:0] after one accept.
- Key reuse:
  - Stimulus: complete block 1 with keep_key=1 at the handshake, then send 16 bytes of 0xFF.
  - Required response: key_out is unchanged (0x0001..0F); plaintext_out = all 0xFF; out_valid after exactly 16 accepts.
- Gappy input:
  - Stimulus: in_valid toggles 1/0 every cycle with key 0x11 bytes and plaintext 0x22 bytes.
  - Required response: out_valid after 32 accepts (about 64 cycles); key_out = 0x1111…11; plaintext_out = 0x2222…22.
- Flush mid-plaintext:
  - Stimulus: after the key and 5 plaintext bytes, pulse flush for 1 cycle while in_valid=1.
  - Required response: in_ready=0 that cycle; then loading_key=1 and cnt=0. A fresh 32-byte sequence yields the correct pair.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while PRESENT.
  - Required response: out_valid=0, key_out=0, plaintext_out=0, state LOAD_KEY on the next cycle.
